// File: rtl/sprite_pixel_mixer.sv
// Sprite pixel mixer: fixed-priority sprite/background select toward VGA,
// plus per-frame sprite overlap tracking and a first-hit pulse.
module sprite_pixel_mixer #(
    parameter int          NUM_OBJECTS = 4,
    parameter logic [7:0]  TRANSPARENT = 8'hFF,
    parameter int          BG_DELAY    = 1
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic [NUM_OBJECTS-1:0]   drawingRequest,
    input  logic [8*NUM_OBJECTS-1:0] objRGB,
    input  logic [7:0]               backgroundRGB,
    output logic [7:0]               RGBOut,
    output logic [NUM_OBJECTS-1:0]   winner,
    output logic                     collision,
    output logic [NUM_OBJECTS-1:0]   collisionFlags,
    output logic                     firstHitPulse,
    output logic                     lastFrameCollision
);

    localparam int CW = $clog2(NUM_OBJECTS) + 1;

    typedef enum logic {
        DISARMED,
        ARMED
    } hit_state_t;

    logic [NUM_OBJECTS-1:0] eff;
    logic [CW-1:0]          eff_cnt;
    logic                   coll_now;
    logic [NUM_OBJECTS-1:0] involved;
    logic [7:0]             bg_aligned;

    logic [7:0]             rgb_q, rgb_d;
    logic [NUM_OBJECTS-1:0] win_q, win_d;
    logic                   coll_q, coll_d;
    logic [NUM_OBJECTS-1:0] flags_q, flags_d;
    logic                   lfc_q, lfc_d;
    logic                   sel_found;

    hit_state_t             hit_state_q;
    logic                   hit_pulse_q;

    // A raised request carrying the transparent code is treated as absent.
    always_comb begin
        eff = '0;
        for (int i = 0; i < NUM_OBJECTS; i++) begin
            eff[i] = drawingRequest[i] &&
                     (objRGB[8*i +: 8] != TRANSPARENT);
        end
    end

    always_comb begin
        eff_cnt = '0;
        for (int i = 0; i < NUM_OBJECTS; i++) begin
            eff_cnt = eff_cnt + CW'(eff[i]);
        end
    end

    if (NUM_OBJECTS > 1) begin : g_coll
        assign coll_now = (eff_cnt >= CW'(2));
    end else begin : g_no_coll
        assign coll_now = 1'b0;
    end

    assign involved = coll_now ? eff : '0;

    if (BG_DELAY == 0) begin : g_bg_pass
        assign bg_aligned = backgroundRGB;
    end else begin : g_bg_pipe
        localparam int PW = 8 * BG_DELAY;
        logic [PW-1:0] bg_pipe_q, bg_pipe_d;

        always_comb bg_pipe_d = (bg_pipe_q << 8) | PW'(backgroundRGB);

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                bg_pipe_q <= '0;
            end else begin
                bg_pipe_q <= bg_pipe_d;
            end
        end

        assign bg_aligned = bg_pipe_q[PW-1 -: 8];
    end

    always_comb begin
        rgb_d     = bg_aligned;
        win_d     = '0;
        sel_found = 1'b0;
        for (int i = 0; i < NUM_OBJECTS; i++) begin
            if (eff[i] && !sel_found) begin
                rgb_d     = objRGB[8*i +: 8];
                win_d[i]  = 1'b1;
                sel_found = 1'b1;
            end
        end
    end

    // On a frame start the current pixel already belongs to the new frame.
    always_comb begin
        coll_d  = coll_now;
        flags_d = startOfFrame ? involved : (flags_q | involved);
        lfc_d   = startOfFrame ? (flags_q != '0) : lfc_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q   <= 8'h00;
            win_q   <= '0;
            coll_q  <= 1'b0;
            flags_q <= '0;
            lfc_q   <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            win_q   <= win_d;
            coll_q  <= coll_d;
            flags_q <= flags_d;
            lfc_q   <= lfc_d;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_state_q <= DISARMED;
            hit_pulse_q <= 1'b0;
        end else begin
            hit_pulse_q <= 1'b0;
            if (startOfFrame) begin
                if (coll_now) begin
                    hit_pulse_q <= 1'b1;
                    hit_state_q <= DISARMED;
                end else begin
                    hit_state_q <= ARMED;
                end
            end else if (hit_state_q == ARMED && coll_now) begin
                hit_pulse_q <= 1'b1;
                hit_state_q <= DISARMED;
            end
        end
    end

    assign RGBOut             = rgb_q;
    assign winner             = win_q;
    assign collision          = coll_q;
    assign collisionFlags     = flags_q;
    assign firstHitPulse      = hit_pulse_q;
    assign lastFrameCollision = lfc_q;

endmodule

// File: tb/tb_sprite_pixel_mixer.sv
// Bench for sprite_pixel_mixer: frame-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_sprite_pixel_mixer;

    localparam int N  = 4;
    localparam int BD = 1;
    localparam int BI = (BD == 0) ? 0 : BD - 1;

    logic           clk;
    logic           resetN;
    logic           sof;
    logic [N-1:0]   req;
    logic [8*N-1:0] obj;
    logic [7:0]     bg;
    logic [7:0]     rgb_out;
    logic [N-1:0]   winner;
    logic           coll;
    logic [N-1:0]   flags;
    logic           pulse;
    logic           lfc;

    int errors = 0;
    int checks = 0;

    sprite_pixel_mixer #(
        .NUM_OBJECTS(N),
        .TRANSPARENT(8'hFF),
        .BG_DELAY(BD)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(sof),
        .drawingRequest(req),
        .objRGB(obj),
        .backgroundRGB(bg),
        .RGBOut(rgb_out),
        .winner(winner),
        .collision(coll),
        .collisionFlags(flags),
        .firstHitPulse(pulse),
        .lastFrameCollision(lfc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: reasons about frames and pixels, not about states.
    logic [7:0]   m_rgb;
    logic [N-1:0] m_win;
    logic         m_coll;
    logic [N-1:0] m_flags;
    logic         m_pulse;
    logic         m_lfc;
    bit           m_in_frame;
    bit           m_hit_done;
    logic [7:0]   bg_hist [4];

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_rgb = 8'h00; m_win = '0; m_coll = 0; m_flags = '0;
            m_pulse = 0; m_lfc = 0; m_in_frame = 0; m_hit_done = 0;
            for (int k = 0; k < 4; k++) bg_hist[k] = 8'h00;
        end else begin
            logic [N-1:0] e;
            logic [7:0]   shown_bg;
            bit           c;
            for (int i = 0; i < N; i++)
                e[i] = req[i] && (obj[8*i +: 8] != 8'hFF);
            c = ($countones(e) >= 2);
            shown_bg = (BD == 0) ? bg : bg_hist[BI];
            for (int k = 3; k > 0; k--) bg_hist[k] = bg_hist[k-1];
            bg_hist[0] = bg;
            m_rgb = shown_bg;
            m_win = '0;
            for (int i = N - 1; i >= 0; i--) begin
                if (e[i]) begin
                    m_rgb = obj[8*i +: 8];
                    m_win = N'(1) << i;
                end
            end
            m_coll = c;
            if (sof) begin
                m_lfc = (m_flags != 0);
                m_flags = c ? e : '0;
                m_in_frame = 1;
                m_hit_done = 0;
            end else begin
                m_flags = m_flags | (c ? e : '0);
            end
            m_pulse = c && m_in_frame && !m_hit_done;
            if (m_pulse) m_hit_done = 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("rgb", 32'(rgb_out), 32'(m_rgb));
        check("winner", 32'(winner), 32'(m_win));
        check("collision", 32'(coll), 32'(m_coll));
        check("flags", 32'(flags), 32'(m_flags));
        check("pulse", 32'(pulse), 32'(m_pulse));
        check("lastframe", 32'(lfc), 32'(m_lfc));
    end

    task automatic set_in(input logic s, input logic [3:0] r,
                          input logic [7:0] o3, input logic [7:0] o2,
                          input logic [7:0] o1, input logic [7:0] o0);
        sof = s;
        req = r;
        obj = {o3, o2, o1, o0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_in(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (n) tick();
    endtask

    initial begin
        resetN = 0;
        bg = 8'h24;
        set_in(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) tick();
        check("t1 rgb in reset", 32'(rgb_out), 32'h00);

        resetN = 1;
        tick();
        check("t1 rgb first cycle", 32'(rgb_out), 32'h00);
        tick();
        check("t1 rgb bg", 32'(rgb_out), 32'h24);
        check("t1 winner", 32'(winner), 32'h0);

        set_in(0, 4'b0110, 8'h00, 8'h45, 8'h05, 8'h00);
        tick();
        check("t2 rgb", 32'(rgb_out), 32'h05);
        check("t2 winner", 32'(winner), 32'b0010);
        check("t2 coll", 32'(coll), 32'h1);
        check("t2 flags", 32'(flags), 32'b0110);
        check("t2 no pulse before frame", 32'(pulse), 32'h0);

        set_in(0, 4'b0011, 8'h00, 8'h00, 8'h6D, 8'hFF);
        tick();
        check("t3 rgb", 32'(rgb_out), 32'h6D);
        check("t3 winner", 32'(winner), 32'b0010);
        check("t3 coll", 32'(coll), 32'h0);
        check("t3 flags", 32'(flags), 32'b0110);

        set_in(0, 4'b0001, 8'h00, 8'h00, 8'h00, 8'hFF);
        tick();
        check("transparent shows bg", 32'(rgb_out), 32'h24);

        set_in(1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        check("t4 flags clear", 32'(flags), 32'h0);
        check("t4 lastframe", 32'(lfc), 32'h1);
        idle(9);
        set_in(0, 4'b0011, 8'h00, 8'h00, 8'h22, 8'h11);
        tick();
        check("t4 pulse px10", 32'(pulse), 32'h1);
        check("t4 rgb px10", 32'(rgb_out), 32'h11);
        check("t4 flags px10", 32'(flags), 32'b0011);
        idle(1);
        check("t4 pulse width", 32'(pulse), 32'h0);
        idle(38);
        set_in(0, 4'b1100, 8'h44, 8'h33, 8'h00, 8'h00);
        tick();
        check("t4 no pulse px50", 32'(pulse), 32'h0);
        check("t4 coll px50", 32'(coll), 32'h1);
        check("t4 flags accum", 32'(flags), 32'b1111);

        set_in(1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        check("t5 flags cleared", 32'(flags), 32'h0);
        check("t5 lastframe set", 32'(lfc), 32'h1);
        idle(20);
        check("t5 lastframe held", 32'(lfc), 32'h1);
        set_in(1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        check("t5 lastframe cleared", 32'(lfc), 32'h0);
        idle(5);

        set_in(1, 4'b0101, 8'h00, 8'h34, 8'h00, 8'h12);
        tick();
        check("t6 sof pulse", 32'(pulse), 32'h1);
        check("t6 sof flags", 32'(flags), 32'b0101);
        check("t6 sof lastframe", 32'(lfc), 32'h0);
        set_in(0, 4'b0101, 8'h00, 8'h34, 8'h00, 8'h12);
        tick();
        check("t6 no second pulse", 32'(pulse), 32'h0);

        set_in(0, 4'b1010, 8'h56, 8'h00, 8'h78, 8'h00);
        #1;
        resetN = 0;
        #1;
        check("t6 rst rgb", 32'(rgb_out), 32'h0);
        check("t6 rst coll", 32'(coll), 32'h0);
        check("t6 rst flags", 32'(flags), 32'h0);
        check("t6 rst winner", 32'(winner), 32'h0);
        tick();
        tick();
        resetN = 1;
        tick();
        check("t6 rst bg discarded", 32'(rgb_out), 32'h78);
        check("t6 disarmed", 32'(pulse), 32'h0);
        check("t6 coll after rst", 32'(coll), 32'h1);
        set_in(1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        idle(2);
        set_in(0, 4'b0110, 8'h00, 8'h9A, 8'hBC, 8'h00);
        tick();
        check("t6 rearmed pulse", 32'(pulse), 32'h1);

        // Back-to-back frame starts and mixed traffic against the model.
        set_in(1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        set_in(1, 4'b0011, 8'h00, 8'h00, 8'h01, 8'h02);
        tick();
        check("b2b sof pulse", 32'(pulse), 32'h1);
        for (int n = 0; n < 300; n++) begin
            logic [7:0] o [4];
            for (int k = 0; k < 4; k++)
                o[k] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            bg = 8'($urandom);
            set_in(($urandom_range(0, 39) == 0), 4'($urandom),
                   o[3], o[2], o[1], o[0]);
            tick();
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
